// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: menu map selection, round survival tracking and best-of match sequencing
// for N-player light-cycle play, driven by edge-detected HID keycodes.
module game_flow_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_MAPS = 2,
  parameter int WINS_TO_MATCH = 3,
  parameter logic [7:0] KEY_ENTER = 8'h28,
  parameter logic [7:0] KEY_UP = 8'h52,
  parameter logic [7:0] KEY_DOWN = 8'h51,
  localparam int MAP_W = NUM_MAPS > 1 ? $clog2(NUM_MAPS) : 1,
  localparam int SC_W = $clog2(WINS_TO_MATCH + 1),
  localparam int PID_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Reset_Game,
  input  logic                        Reset_Round,
  input  logic [7:0]                  keycode,
  input  logic [NUM_PLAYERS-1:0]      crash,
  output logic [2:0]                  Game_State,
  output logic [MAP_W-1:0]            map_select,
  output logic [NUM_PLAYERS-1:0]      alive,
  output logic [NUM_PLAYERS*SC_W-1:0] scores,
  output logic [PID_W-1:0]            winner_id,
  output logic                        winner_valid,
  output logic                        load_background
);
  typedef enum logic [2:0] {
    MENU          = 3'd0,
    ROUND_PAUSED  = 3'd1,
    ROUND_STARTED = 3'd2,
    ROUND_OVER    = 3'd3,
    MATCH_OVER    = 3'd4
  } state_t;
  state_t state, state_nx;
  logic [7:0] key_prev;
  logic armed, p_enter, p_up, p_down, one_left;
  logic [MAP_W-1:0] map_nx;
  logic [NUM_PLAYERS-1:0] alive_nx, alive_rnd;
  logic [NUM_PLAYERS*SC_W-1:0] scores_nx;
  logic [PID_W-1:0] wid_nx, win_idx;
  logic [SC_W-1:0] win_sc, win_inc;
  logic wv_nx, load_nx;
  // armed stays low for the first edge after Reset_n release so a key held through reset is not seen as a press
  assign p_enter = armed && keycode == KEY_ENTER && key_prev != KEY_ENTER;
  assign p_up = armed && keycode == KEY_UP && key_prev != KEY_UP;
  assign p_down = armed && keycode == KEY_DOWN && key_prev != KEY_DOWN;
  assign alive_rnd = alive & ~crash;
  assign one_left = alive_rnd != '0 && (alive_rnd & (alive_rnd - NUM_PLAYERS'(1))) == '0;
  assign Game_State = state;
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (alive_rnd[i]) win_idx = PID_W'(i);
    win_sc = scores[win_idx*SC_W +: SC_W];
    win_inc = win_sc == SC_W'(WINS_TO_MATCH) ? win_sc : win_sc + SC_W'(1);
  end
  always_comb begin
    state_nx = state;
    map_nx = map_select;
    alive_nx = alive;
    scores_nx = scores;
    wid_nx = winner_id;
    wv_nx = winner_valid;
    case (state)
      MENU: begin
        if (p_up) map_nx = map_select == MAP_W'(NUM_MAPS - 1) ? '0 : map_select + MAP_W'(1);
        if (p_down) map_nx = map_select == '0 ? MAP_W'(NUM_MAPS - 1) : map_select - MAP_W'(1);
        if (p_enter) begin
          state_nx = ROUND_PAUSED;
          alive_nx = '1;
          scores_nx = '0;
        end
      end
      ROUND_PAUSED: if (p_enter) state_nx = ROUND_STARTED;
      ROUND_STARTED: begin
        alive_nx = alive_rnd;
        if (one_left) begin
          scores_nx[win_idx*SC_W +: SC_W] = win_inc;
          wid_nx = win_idx;
          wv_nx = 1'b1;
          state_nx = win_inc == SC_W'(WINS_TO_MATCH) ? MATCH_OVER : ROUND_OVER;
        end else if (alive_rnd == '0) begin
          wv_nx = 1'b0;
          state_nx = ROUND_OVER;
        end else if (Reset_Round) begin
          state_nx = ROUND_PAUSED;
          alive_nx = '1;
        end
      end
      ROUND_OVER: if (p_enter) begin
        state_nx = ROUND_PAUSED;
        alive_nx = '1;
      end
      MATCH_OVER: if (p_enter) begin
        state_nx = MENU;
        scores_nx = '0;
      end
      default: state_nx = MENU;
    endcase
    load_nx = state_nx != state && state_nx != ROUND_STARTED;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) armed <= 1'b0;
    else armed <= 1'b1;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= MENU;
      map_select <= '0;
      alive <= '1;
      scores <= '0;
      winner_id <= '0;
      winner_valid <= 1'b0;
      load_background <= 1'b0;
      key_prev <= '0;
    end else if (Reset_Game) begin
      state <= MENU;
      map_select <= '0;
      alive <= '1;
      scores <= '0;
      winner_id <= '0;
      winner_valid <= 1'b0;
      load_background <= 1'b0;
      key_prev <= '0;
    end else begin
      state <= state_nx;
      map_select <= map_nx;
      alive <= alive_nx;
      scores <= scores_nx;
      winner_id <= wid_nx;
      winner_valid <= wv_nx;
      load_background <= load_nx;
      key_prev <= keycode;
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench for game_flow_ctrl (3 players, 3 maps, 2 wins per match);
// stimulus queues hand-computed expectations, a monitor pops and compares them after each edge.
module tb_game_flow_ctrl;
  localparam logic [7:0] EN = 8'h28, UP = 8'h52, DN = 8'h51;
  logic Clk = 1'b0, Reset_n, Reset_Game, Reset_Round;
  logic [7:0] keycode;
  logic [2:0] crash, Game_State, alive;
  logic [1:0] map_select, winner_id;
  logic [5:0] scores;
  logic winner_valid, load_background;
  typedef struct {
    string nm;
    logic [2:0] st;
    logic [1:0] map;
    logic [2:0] alive;
    logic [5:0] sc;
    logic [1:0] wid;
    logic wv;
    logic lb;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [1:0] e_map = 2'd0, e_wid = 2'd0;
  logic [2:0] e_alive = 3'b111;
  logic [5:0] e_sc = 6'd0;
  logic e_wv = 1'b0;
  game_flow_ctrl #(.NUM_PLAYERS(3), .NUM_MAPS(3), .WINS_TO_MATCH(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Reset_Game(Reset_Game), .Reset_Round(Reset_Round),
    .keycode(keycode), .crash(crash), .Game_State(Game_State), .map_select(map_select),
    .alive(alive), .scores(scores), .winner_id(winner_id), .winner_valid(winner_valid),
    .load_background(load_background)
  );
  always #5 Clk = ~Clk;
  task automatic cmp(input exp_t e);
    n_cmp++;
    if (Game_State !== e.st || map_select !== e.map || alive !== e.alive || scores !== e.sc ||
        winner_id !== e.wid || winner_valid !== e.wv || load_background !== e.lb) begin
      n_bad++;
      $display("FAIL %s: got st=%0d map=%0d alive=%b sc=%b wid=%0d wv=%b lb=%b, want st=%0d map=%0d alive=%b sc=%b wid=%0d wv=%b lb=%b",
               e.nm, Game_State, map_select, alive, scores, winner_id, winner_valid, load_background,
               e.st, e.map, e.alive, e.sc, e.wid, e.wv, e.lb);
    end
  endtask
  task automatic step(input string nm, input logic [7:0] k, input logic [2:0] cr, input logic rr,
                      input logic rg, input logic [2:0] st, input logic lb);
    exp_t e;
    keycode = k;
    crash = cr;
    Reset_Round = rr;
    Reset_Game = rg;
    e.nm = nm; e.st = st; e.map = e_map; e.alive = e_alive; e.sc = e_sc;
    e.wid = e_wid; e.wv = e_wv; e.lb = lb;
    q.push_back(e);
    @(posedge Clk);
    #2;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e);
      end
    end
  end
  initial begin
    exp_t r;
    Reset_n = 1'b0; Reset_Game = 1'b0; Reset_Round = 1'b0; keycode = 8'h00; crash = 3'b000;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0);
    e_map = 2; step("down_wrap", DN, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    e_map = 0; step("up_wrap", UP, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    e_map = 1; step("up", UP, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    e_map = 2;
    for (int i = 0; i < 10; i++) step("hold_up", UP, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    step("menu_enter", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b001; e_sc = 6'b000001; e_wid = 0; e_wv = 1;
    step("round_win", 0, 3'b110, 0, 0, 3, 1);
    step("idle", 0, 0, 0, 0, 3, 0);
    step("crash_ignored", 0, 3'b111, 0, 0, 3, 0);
    e_alive = 3'b111; step("next_round", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b110; step("crash_one", 0, 3'b001, 0, 0, 2, 0);
    e_alive = 3'b000; e_wv = 0; step("draw", 0, 3'b110, 1, 0, 3, 1);
    step("idle", 0, 0, 0, 0, 3, 0);
    e_alive = 3'b111; step("next_round", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b101; step("crash_mid", 0, 3'b010, 0, 0, 2, 0);
    e_alive = 3'b111; step("round_abort", 0, 0, 1, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b100; e_sc = 6'b010001; e_wid = 2; e_wv = 1;
    step("p2_round", 0, 3'b011, 0, 0, 3, 1);
    step("idle", 0, 0, 0, 0, 3, 0);
    e_alive = 3'b111; step("next_round", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b110; step("m_crash_a", 0, 3'b001, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b100; e_sc = 6'b100001; step("match_win", 0, 3'b010, 0, 0, 4, 1);
    step("match_hold", 0, 3'b010, 0, 0, 4, 0);
    e_sc = 6'd0; step("to_menu", EN, 0, 0, 0, 0, 1);
    step("idle", 0, 0, 0, 0, 0, 0);
    e_alive = 3'b111; step("menu_enter", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_map = 0; e_wid = 0; e_wv = 0;
    step("reset_game", 0, 3'b011, 0, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    e_map = 1; step("up", UP, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    step("menu_enter", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    step("start", EN, 0, 0, 0, 2, 0);
    step("idle", 0, 0, 0, 0, 2, 0);
    e_alive = 3'b110; step("crash_one", 0, 3'b001, 0, 0, 2, 0);
    keycode = EN;
    crash = 3'b000;
    Reset_n = 1'b0;
    #1;
    e_map = 0; e_alive = 3'b111; e_sc = 6'd0; e_wid = 0; e_wv = 0;
    r.nm = "async_reset"; r.st = 0; r.map = e_map; r.alive = e_alive; r.sc = e_sc;
    r.wid = e_wid; r.wv = e_wv; r.lb = 1'b0;
    cmp(r);
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    step("held_enter_a", EN, 0, 0, 0, 0, 0);
    step("held_enter_b", EN, 0, 0, 0, 0, 0);
    step("held_enter_c", EN, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);
    step("enter_after", EN, 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller for N-player light-cycle play. It handles menu map selection with wrap-around and edge-detected keyboard input, and tracks which players are still alive in each round. It also keeps per-player match scores and sequences rounds up to a best-of match result. It sits between the USB keycode register and the renderer, background loader, and per-player motion blocks.

## Interface
- NUM_PLAYERS, 2: number of players, 2..4.
- NUM_MAPS, 2: number of selectable maps, 1..8.
- WINS_TO_MATCH, 3: round wins needed to win the match, 1..15.
- KEY_ENTER, 8'h28 / KEY_UP, 8'h52 / KEY_DOWN, 8'h51: HID keycodes used by the block.
- Derived: MAP_W = max(1, clog2(NUM_MAPS)); SC_W = clog2(WINS_TO_MATCH+1); PID_W = max(1, clog2(NUM_PLAYERS)).
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Reset_Game  in  1  synchronous restart to MENU; clears scores and map.
- Reset_Round  in  1  synchronous round abort; effective only in ROUND_STARTED.
- keycode  in  8  current keyboard keycode; 8'h00 = none.
- crash  in  NUM_PLAYERS  per-player crash strobe, level-sampled each cycle.
- Game_State  out  3  current state encoding (see Operation).
- map_select  out  MAP_W  selected map index, 0..NUM_MAPS-1.
- alive  out  NUM_PLAYERS  players still alive this round.
- scores  out  NUM_PLAYERS*SC_W  packed scores; player p occupies bits [p*SC_W +: SC_W].
- winner_id  out  PID_W  last round or match winner.
- winner_valid  out  1  high when winner_id is meaningful; low after a draw.
- load_background  out  1  one-cycle pulse requesting a background reload.

## Operation
- States and encodings: MENU=0, ROUND_PAUSED=1, ROUND_STARTED=2, ROUND_OVER=3, MATCH_OVER=4. Codes 5..7 are illegal and recover to MENU on the next cycle.
- Key press = (keycode == K) and (keycode_prev != K). keycode_prev is registered every cycle, and a held key acts once.
- MENU:
  - UP press: map_select +1, wrapping NUM_MAPS-1 -> 0.
  - DOWN press: map_select -1, wrapping 0 -> NUM_MAPS-1.
  - UP and DOWN can never both be pressed in one cycle (single keycode).
  - ENTER press: go to ROUND_PAUSED, set alive to all ones, clear scores.
- ROUND_PAUSED: ENTER press -> ROUND_STARTED.
- ROUND_STARTED:
  - alive_next = alive & ~crash. crash bits on dead players are ignored.
  - Resolution is evaluated on alive_next:
    - popcount(alive_next) == 1: that player's score +1 (saturating at WINS_TO_MATCH). winner_id = its index, winner_valid = 1.
    - popcount(alive_next) == 0 (simultaneous last crash): draw. No score change, winner_valid = 0.
    - popcount >= 2: stay.
  - On resolution: if the winner's new score == WINS_TO_MATCH -> MATCH_OVER, else -> ROUND_OVER.
  - Reset_Round with no resolution in the same cycle: -> ROUND_PAUSED, alive set to all ones, scores kept.
- ROUND_OVER: ENTER press -> ROUND_PAUSED, alive set to all ones.
- MATCH_OVER: ENTER press -> MENU, scores cleared, map_select kept.
- Priority, highest first: Reset_n, Reset_Game, round resolution, Reset_Round, key action.
- crash is ignored outside ROUND_STARTED.

## Timing
- Reset values (Reset_n low, or Reset_Game high on a clock edge):
  - Game_State = 0, map_select = 0, alive = all ones, scores = 0.
  - winner_id = 0, winner_valid = 0, load_background = 0, keycode_prev = 8'h00.
- All outputs are registered. A triggering input in cycle t changes outputs at edge t+1.
- Key-press latency: keycode change at edge t -> state/map update at edge t+1.
- load_background is high for exactly the one cycle after any transition into ROUND_PAUSED, ROUND_OVER, MATCH_OVER or MENU. It is not raised by ROUND_PAUSED -> ROUND_STARTED or by Reset.
- Score update, alive update and state change happen on the same edge.
- Reset_n deassertion is consumed synchronously. The first key action is accepted no earlier than the second edge after release.

## Test plan
- Map wrap, NUM_MAPS=3: in MENU press DOWN -> map_select=2. Press UP twice -> 1. Hold UP for 10 cycles -> only +1.
- Round win, 2 players: ENTER, ENTER, then crash=2'b10 for 1 cycle -> next edge Game_State=3, scores[0]=1, winner_id=0, winner_valid=1, load_background pulses once.
- Draw: in ROUND_STARTED apply crash=2'b11 -> Game_State=3, scores unchanged, winner_valid=0. Same-cycle Reset_Round is ignored.
- Match, WINS_TO_MATCH=2, NUM_PLAYERS=3:
  - Round 1: player 2 survives.
  - Round 2: crash=3'b001, then later 3'b010.
  - Result: Game_State=4, scores[2]=2. ENTER -> Game_State=0, scores all 0, map kept.
- Reset_Round in ROUND_STARTED with crash=0 -> Game_State=1, alive=all ones, scores unchanged, load_background pulse.
- Asynchronous Reset_n asserted mid ROUND_STARTED, off-edge -> all outputs go to reset values immediately. Held ENTER across release triggers no transition.
